// File: rtl/spi_target_if_if.sv
// SPI pins plus the register-wrapper side of the SPI target front end.
// slave = the target front end, master = host pins and the register wrapper.
interface spi_target_if_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [6:0] reg_addr;
  logic       rw_out;
  logic       addr_dv;
  logic [7:0] rx_d;
  logic       rxdv;
  logic [7:0] tx_d;
  logic       tx_en;

  modport slave (
    input  sclk, cs_n, mosi, tx_d, tx_en,
    output miso, miso_oe, reg_addr, rw_out, addr_dv, rx_d, rxdv
  );

  modport master (
    output sclk, cs_n, mosi, tx_d, tx_en,
    input  miso, miso_oe, reg_addr, rw_out, addr_dv, rx_d, rxdv
  );
endinterface

// File: rtl/spi_target_if.sv
// SPI mode-0 target: command byte -> reg_addr/rw_out, write bytes -> rx_d/rxdv, read byte -> miso.
// SYNC_STAGES+2 clk from 8th sclk rise to addr_dv/rxdv; no backpressure, rxdv must be taken when pulsed.
module spi_target_if #(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  spi_target_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d;
  logic       sclk_s, cs_s, mosi_s;
  logic       rise, fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic       byte_done;
  logic       tx_load;
  logic       rd_active;
  logic [6:0] reg_addr_q;
  logic       rw_q;
  logic       addr_dv_q;
  logic [7:0] rx_d_q;
  logic       rxdv_q;
  logic       miso_oe_q;

  // cs_n synchronisers reset to deasserted so a low pin after reset looks like a fresh select
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign rd_active = (state == DATA) && rw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_s) state_nxt = CMD;
      CMD:     if (cs_s) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Deselect wins over a coincident rise, so the bit is dropped and framing restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= 8'h00;
      byte_done <= 1'b0;
    end else begin
      byte_done <= rise && !cs_s && (bit_cnt == 3'd7);
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (!rd_active) rx_sr <= {rx_sr[6:0], mosi_s};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr_q <= 7'h00;
      rw_q       <= 1'b0;
      addr_dv_q  <= 1'b0;
      rx_d_q     <= 8'h00;
      rxdv_q     <= 1'b0;
      tx_load    <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      rxdv_q    <= 1'b0;
      tx_load   <= 1'b0;
      miso_oe_q <= (state_nxt != IDLE);
      if (cs_s) begin
        addr_dv_q <= 1'b0;
        rw_q      <= 1'b0;
      end else if (byte_done && state == CMD) begin
        reg_addr_q <= rx_sr[6:0];
        rw_q       <= rx_sr[7];
        addr_dv_q  <= 1'b1;
        tx_load    <= rx_sr[7];
      end else if (byte_done && state == DATA) begin
        if (rw_q) begin
          tx_load <= 1'b1;
        end else begin
          rx_d_q <= rx_sr;
          rxdv_q <= 1'b1;
        end
      end
    end
  end

  // The fall that closes a byte (bit_cnt wrapped to 0) must not shift, so the reloaded MSB survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr <= 8'h00;
    end else if (tx_load) begin
      tx_sr <= bus.tx_en ? bus.tx_d : 8'h00;
    end else if (rd_active && fall && !cs_s && bit_cnt != 3'd0) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign bus.miso     = rd_active ? tx_sr[7] : MISO_IDLE;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.rw_out   = rw_q;
  assign bus.addr_dv  = addr_dv_q;
  assign bus.rx_d     = rx_d_q;
  assign bus.rxdv     = rxdv_q;

endmodule

// File: tb/tb_spi_target_if.sv
// Directed bench for spi_target_if: write, read, burst, abort and mid-transaction reset.
module tb_spi_target_if;

  localparam time CLK_HALF  = 5ns;
  localparam time SCLK_HALF = 80ns;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] rx_q[$];
  logic [7:0] rd_byte;
  logic [7:0] dummy;
  int   base;

  spi_target_if_if bus();

  spi_target_if #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_HALF) clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset_n && bus.rxdv) rx_q.push_back(bus.rx_d);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts out the top nbits of tx MSB first; miso is sampled just before each rise
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      #(SCLK_HALF);
      rx = {rx[6:0], bus.miso};
      bus.sclk = 1'b1;
      #(SCLK_HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    #(SCLK_HALF);
    bus.cs_n = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    bus.sclk   = 1'b0;
    bus.cs_n   = 1'b1;
    bus.mosi   = 1'b0;
    bus.tx_d   = 8'h00;
    bus.tx_en  = 1'b0;
    wait_clk(4);
    check_eq("rst_miso",     {31'd0, bus.miso},    32'h0);
    check_eq("rst_miso_oe",  {31'd0, bus.miso_oe}, 32'h0);
    check_eq("rst_reg_addr", {25'd0, bus.reg_addr}, 32'h0);
    check_eq("rst_rw_out",   {31'd0, bus.rw_out},  32'h0);
    check_eq("rst_addr_dv",  {31'd0, bus.addr_dv}, 32'h0);
    check_eq("rst_rx_d",     {24'd0, bus.rx_d},    32'h0);
    check_eq("rst_rxdv",     {31'd0, bus.rxdv},    32'h0);
    reset_n = 1'b1;
    wait_clk(4);

    // Single write 0x05 <- 0xA5
    cs_low();
    check_eq("wr_miso_oe", {31'd0, bus.miso_oe}, 32'h1);
    spi_byte(8'h05, 8, dummy);
    wait_clk(6);
    check_eq("wr_addr_dv",  {31'd0, bus.addr_dv}, 32'h1);
    check_eq("wr_rw_out",   {31'd0, bus.rw_out},  32'h0);
    check_eq("wr_reg_addr", {25'd0, bus.reg_addr}, 32'h05);
    spi_byte(8'hA5, 8, dummy);
    wait_clk(6);
    check_eq("wr_rxdv_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("wr_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
    check_eq("wr_rx_d", {24'd0, bus.rx_d}, 32'hA5);
    cs_high();
    check_eq("wr_end_addr_dv",  {31'd0, bus.addr_dv}, 32'h0);
    check_eq("wr_end_miso_oe",  {31'd0, bus.miso_oe}, 32'h0);
    check_eq("wr_end_reg_addr", {25'd0, bus.reg_addr}, 32'h05);

    // Read 0x84 with the wrapper returning 0x3C, two bytes to cover the burst reload
    bus.tx_d  = 8'h3C;
    bus.tx_en = 1'b1;
    cs_low();
    spi_byte(8'h84, 8, dummy);
    wait_clk(6);
    check_eq("rd_rw_out",   {31'd0, bus.rw_out},  32'h1);
    check_eq("rd_reg_addr", {25'd0, bus.reg_addr}, 32'h04);
    spi_byte(8'hFF, 8, rd_byte);
    check_eq("rd_byte0", {24'd0, rd_byte}, 32'h3C);
    spi_byte(8'hFF, 8, rd_byte);
    check_eq("rd_byte1", {24'd0, rd_byte}, 32'h3C);
    cs_high();
    check_eq("rd_no_rxdv", rx_q.size(), 1);
    check_eq("rd_idle_miso", {31'd0, bus.miso}, 32'h0);
    check_eq("rd_rx_d_kept", {24'd0, bus.rx_d}, 32'hA5);

    // Read 0x83 with tx_en low must shift zeros
    bus.tx_d  = 8'hFF;
    bus.tx_en = 1'b0;
    cs_low();
    spi_byte(8'h83, 8, dummy);
    spi_byte(8'h00, 8, rd_byte);
    check_eq("rd_noen_byte", {24'd0, rd_byte}, 32'h00);
    check_eq("rd_noen_addr", {25'd0, bus.reg_addr}, 32'h03);
    cs_high();

    // Burst write 0x05 <- 0x11, 0x22
    base = rx_q.size();
    cs_low();
    spi_byte(8'h05, 8, dummy);
    spi_byte(8'h11, 8, dummy);
    spi_byte(8'h22, 8, dummy);
    wait_clk(6);
    check_eq("bw_rxdv_cnt", rx_q.size() - base, 2);
    if (rx_q.size() >= base + 2) begin
      check_eq("bw_byte0", {24'd0, rx_q[base]},   32'h11);
      check_eq("bw_byte1", {24'd0, rx_q[base+1]}, 32'h22);
    end
    check_eq("bw_reg_addr", {25'd0, bus.reg_addr}, 32'h05);
    cs_high();

    // Abort after 4 data bits, then abort after 3 command bits
    base = rx_q.size();
    cs_low();
    spi_byte(8'h05, 8, dummy);
    spi_byte(8'hF0, 4, dummy);
    cs_high();
    check_eq("ab_data_rxdv", rx_q.size() - base, 0);
    check_eq("ab_data_rx_d", {24'd0, bus.rx_d}, 32'h22);
    cs_low();
    spi_byte(8'h85, 3, dummy);
    wait_clk(10);
    check_eq("ab_cmd_addr_dv", {31'd0, bus.addr_dv}, 32'h0);
    cs_high();
    check_eq("ab_cmd_reg_addr", {25'd0, bus.reg_addr}, 32'h05);

    // Reset in the middle of a read data byte
    bus.tx_d  = 8'h3C;
    bus.tx_en = 1'b1;
    cs_low();
    spi_byte(8'h84, 8, dummy);
    spi_byte(8'h00, 4, dummy);
    reset_n = 1'b0;
    #1;
    check_eq("mr_addr_dv",  {31'd0, bus.addr_dv}, 32'h0);
    check_eq("mr_rw_out",   {31'd0, bus.rw_out},  32'h0);
    check_eq("mr_miso_oe",  {31'd0, bus.miso_oe}, 32'h0);
    check_eq("mr_reg_addr", {25'd0, bus.reg_addr}, 32'h0);
    check_eq("mr_rx_d",     {24'd0, bus.rx_d},    32'h0);
    check_eq("mr_miso",     {31'd0, bus.miso},    32'h0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    base = rx_q.size();
    cs_low();
    spi_byte(8'h05, 8, dummy);
    spi_byte(8'h5A, 8, dummy);
    wait_clk(6);
    check_eq("mr_post_rxdv", rx_q.size() - base, 1);
    if (rx_q.size() > base) check_eq("mr_post_byte", {24'd0, rx_q[base]}, 32'h5A);
    check_eq("mr_post_addr", {25'd0, bus.reg_addr}, 32'h05);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
